dispatch_queue: RTL and testbench
=================================

# dispatch_queue

Parametrised successor to the 2-wide dispatch stage. It buffers renamed micro-ops in a circular dispatch queue and issues them in program order, up to DISP_W per cycle, to the ROB, reservation station and LSU. It tracks physical-register readiness in an internal scoreboard with CDB bypass, and manages RS and LSU capacity with credit counters instead of a full flag. Fetch/rename width, dispatch width, queue depth, CDB width and memory-ops-per-cycle are all parameters.

## Interface
Parameters:
- FETCH_W, 2, rename lanes enqueued per cycle
- DISP_W, 2, dispatch lanes per cycle
- DQ_DEPTH, 8, queue entries; power of 2, ≥ FETCH_W+DISP_W
- XLEN, 32, datapath width
- PHYS_W, 6, physical tag width (PREGS = 2^PHYS_W)
- ROB_IDX_W, 5, ROB index width
- CDB_W, 2, CDB broadcast ports
- MEM_PER_CYCLE, 1, maximum load/store/CAS dispatches per cycle
- RS_CREDITS, 16, RS capacity
- LSU_CREDITS, 8, LSU queue capacity

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous reset, active-low
- flush_pipeline  in  1  synchronous squash
- ren_valid  in  FETCH_W  lane valids; must be prefix-contiguous
- ren_uop  in  FETCH_W×dispatch_uop_t  renamed uops
- ren_ready  out  1  queue accepts the full rename group this cycle
- prf_rtag  out  2·DISP_W×PHYS_W  PRF read tags (lane k: ports 2k, 2k+1)
- prf_rdata  in  2·DISP_W×XLEN  combinational PRF data
- cdb_valid / cdb_tag / cdb_value  in  CDB_W / CDB_W×PHYS_W / CDB_W×XLEN  writeback broadcast
- rob_free  in  ROB_IDX_W+1  free ROB slots
- rob_alloc_idx  in  DISP_W×ROB_IDX_W  ROB indices for the next DISP_W allocations
- rob_alloc_en, rs_alloc_en, lsu_alloc_en  out  DISP_W each  per-lane allocation strobes
- disp_uop  out  DISP_W×dispatch_uop_t  shared dispatch payload
- disp_rob_idx  out  DISP_W×ROB_IDX_W  ROB index per lane
- disp_src1_val, disp_src2_val  out  DISP_W×XLEN  operand values
- disp_src1_ready, disp_src2_ready  out  DISP_W  operand ready bits
- rs_release  in  $clog2(RS_CREDITS+1)  RS entries freed this cycle
- lsu_release  in  $clog2(LSU_CREDITS+1)  LSU entries freed this cycle

## Operation
**Enqueue**
- ren_ready = !flush_pipeline && (DQ_DEPTH − count) ≥ FETCH_W.
- The ready check uses the current count only. Slots freed by same-cycle dispatch are not reused.
- On ren_ready && |ren_valid: write popcount(ren_valid) entries at tail and advance tail by that count, modulo DQ_DEPTH.

**Dispatch scan**
- Entries at head+k, k = 0..DISP_W−1, are scanned in order.
- Lane k dispatches only if all of the following hold:
  - lanes 0..k−1 dispatched;
  - the entry is valid;
  - rob_free > k;
  - the uop class has a resource:
    - ALU/branch: rs_cnt > number of RS allocations in lanes 0..k−1;
    - load/store/CAS: lsu_cnt > number of earlier LSU allocations, and memory count < MEM_PER_CYCLE.
- The first lane that fails blocks all younger lanes.
- A dispatched lane asserts rob_alloc_en plus exactly one of rs_alloc_en or lsu_alloc_en.
- head advances by n, the number of dispatched lanes.

**Operands**
- No source (rsX_valid = 0): ready = 1.
  - src1 value = 0.
  - src2 value = imm.
- prsX == 0: ready = 1, value = 0.
- Otherwise, the initial readiness comes from the scoreboard, with the PRF value.
- CDB override: a match on any cdb_tag forces ready = 1 and value = cdb_value. The highest CDB port wins.
- Intra-group dependency: a source that equals the prd of an older dispatching lane with rd_valid forces ready = 0. This overrides the CDB match.

**Scoreboard (PREGS bits)**
- Set on cdb_valid.
- Cleared for each dispatched lane with rd_valid and prd ≠ 0.
- If a clear and a set hit the same tag in one cycle, the clear wins.

**Credits**
- rs_cnt ← rs_cnt − RS allocations + rs_release.
- lsu_cnt ← lsu_cnt − LSU allocations + lsu_release.
- A result above capacity saturates at capacity and fires a simulation assertion.

**Flush** (highest priority)
- In the flush cycle, all alloc_en outputs are 0 and ren_ready is 0.
- Next cycle:
  - head = tail = count = 0;
  - scoreboard all ones;
  - rs_cnt = RS_CREDITS and lsu_cnt = LSU_CREDITS;
  - release inputs from the flush cycle are ignored.
- Flush is asserted only when no older uop is pending writeback.

## Timing
- Enqueue-to-dispatch latency is 1 cycle minimum. There is no bypass around the queue.
- Dispatch outputs are combinational from the head entries, scoreboard, PRF and CDB. Consumers sample them on the clk edge.
- A scoreboard clear is visible to the next cycle's scan. The same cycle is covered by the intra-group rule.
- Reset values:
  - count = head = tail = 0;
  - scoreboard all ones;
  - credits full;
  - all alloc_en outputs = 0;
  - ren_ready = 1 after reset deassertion;
  - payload outputs 0.
- Reset asserted mid-operation discards the queue contents asynchronously.
- Boundaries:
  - count = DQ_DEPTH−FETCH_W+1 gives ren_ready = 0.
  - count = 0: no alloc_en.
  - Pointer wrap is seamless across DQ_DEPTH−1 → 0.

## Structure
- Add to core_pkg:
  - dispatch_uop_t, with fields opcode, alu_func, prs1, prs2, prd, rs1_valid, rs2_valid, rd_valid, arch_rs1, arch_rs2, arch_rd, imm, pc, uclass;
  - the uop_class_e enum {UC_ALU, UC_BRANCH, UC_LOAD, UC_STORE, UC_CAS}.
- Sub-module dispatch_scoreboard: PREGS ready bits, DISP_W clear ports, CDB_W set ports, flush-to-all-ready, and 2·DISP_W combinational lookup ports.

## Test plan
- Reset, then enqueue 2 ALU uops (prd 5, 6) with rob_free = 8 → both dispatch next cycle; rob_alloc_en = 11, rs_alloc_en = 11; scoreboard[5], scoreboard[6] = 0.
- Lane 0 prd = 7, lane 1 prs1 = 7 in the same group → disp_src1_ready[1] = 0, even with cdb_tag = 7 valid.
- Two loads at the head with MEM_PER_CYCLE = 1 → lsu_alloc_en = 01; second load dispatches the following cycle.
- rs_cnt = 1 with 2 ALU uops at the head → only lane 0 dispatches; rs_release = 1 next cycle → lane 1 dispatches.
- Fill to count = 7 with DQ_DEPTH = 8 → ren_ready = 0. Then drain across the wrap point → entries emerge in enqueue order and ren_ready returns at count ≤ 6.
- Flush with 5 entries queued and rs_cnt = 3 → no alloc that cycle; next cycle count = 0, rs_cnt = 16, scoreboard all ones.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types for the dispatch stage.
//   dispatch_uop_t : renamed micro-op carried through the dispatch queue
//   uop_class_e    : functional class, selects RS or LSU as the destination
package core_pkg;

    localparam int unsigned CORE_XLEN   = 32;
    localparam int unsigned CORE_PHYS_W = 6;

    typedef enum logic [2:0] {
        UC_ALU,
        UC_BRANCH,
        UC_LOAD,
        UC_STORE,
        UC_CAS
    } uop_class_e;

    typedef struct packed {
        logic [6:0]             opcode;
        logic [3:0]             alu_func;
        logic [CORE_PHYS_W-1:0] prs1;
        logic [CORE_PHYS_W-1:0] prs2;
        logic [CORE_PHYS_W-1:0] prd;
        logic                   rs1_valid;
        logic                   rs2_valid;
        logic                   rd_valid;
        logic [4:0]             arch_rs1;
        logic [4:0]             arch_rs2;
        logic [4:0]             arch_rd;
        logic [CORE_XLEN-1:0]   imm;
        logic [CORE_XLEN-1:0]   pc;
        uop_class_e             uclass;
    } dispatch_uop_t;

    // Memory-class uops go to the LSU; everything else to the RS.
    function automatic logic is_mem_class(input uop_class_e c);
        return (c == UC_LOAD) || (c == UC_STORE) || (c == UC_CAS);
    endfunction

endpackage

// File: rtl/dispatch_scoreboard.sv
// Physical-register ready scoreboard.
//   clk, reset_n     : clock, asynchronous active-low reset (all ready)
//   flush            : synchronous return to all-ready
//   clr_en / clr_tag : per dispatch lane, mark destination not ready
//   set_en / set_tag : per CDB port, mark written-back tag ready
//   rd_tag / rd_ready: combinational lookups (two per dispatch lane)
module dispatch_scoreboard #(
    parameter int unsigned PHYS_W = 6,
    parameter int unsigned DISP_W = 2,
    parameter int unsigned CDB_W  = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic [DISP_W-1:0]                clr_en,
    input  logic [DISP_W-1:0][PHYS_W-1:0]    clr_tag,
    input  logic [CDB_W-1:0]                 set_en,
    input  logic [CDB_W-1:0][PHYS_W-1:0]     set_tag,
    input  logic [2*DISP_W-1:0][PHYS_W-1:0]  rd_tag,
    output logic [2*DISP_W-1:0]              rd_ready
);

    localparam int unsigned PREGS = 1 << PHYS_W;

    logic [PREGS-1:0] ready_q, ready_d;

    // Sets applied before clears so a same-cycle clear wins.
    always_comb begin
        ready_d = ready_q;
        if (flush) begin
            ready_d = '1;
        end else begin
            for (int c = 0; c < CDB_W; c++) begin
                if (set_en[c]) ready_d[set_tag[c]] = 1'b1;
            end
            for (int d = 0; d < DISP_W; d++) begin
                if (clr_en[d]) ready_d[clr_tag[d]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_q <= '1;
        else          ready_q <= ready_d;
    end

    always_comb begin
        for (int i = 0; i < 2 * DISP_W; i++) rd_ready[i] = ready_q[rd_tag[i]];
    end

endmodule

// File: rtl/dispatch_queue.sv
// Circular dispatch queue: buffers renamed uops and issues up to DISP_W per cycle
// in program order to ROB, RS and LSU, with operand readiness and credit tracking.
//   ren_*           : rename-side enqueue (prefix-contiguous valids, all-or-nothing)
//   prf_rtag/rdata  : combinational PRF reads for the head lanes
//   cdb_*           : writeback broadcast (scoreboard set and operand bypass)
//   rob_*           : ROB free count / indices in, allocation strobes out
//   rs_/lsu_alloc_en: per-lane destination strobes; *_release return credits
//   disp_*          : dispatch payload and resolved operands per lane
module dispatch_queue
    import core_pkg::*;
#(
    parameter int unsigned FETCH_W       = 2,
    parameter int unsigned DISP_W        = 2,
    parameter int unsigned DQ_DEPTH      = 8,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PHYS_W        = 6,
    parameter int unsigned ROB_IDX_W     = 5,
    parameter int unsigned CDB_W         = 2,
    parameter int unsigned MEM_PER_CYCLE = 1,
    parameter int unsigned RS_CREDITS    = 16,
    parameter int unsigned LSU_CREDITS   = 8
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    flush_pipeline,
    input  logic [FETCH_W-1:0]                      ren_valid,
    input  dispatch_uop_t [FETCH_W-1:0]             ren_uop,
    output logic                                    ren_ready,
    output logic [2*DISP_W-1:0][PHYS_W-1:0]         prf_rtag,
    input  logic [2*DISP_W-1:0][XLEN-1:0]           prf_rdata,
    input  logic [CDB_W-1:0]                        cdb_valid,
    input  logic [CDB_W-1:0][PHYS_W-1:0]            cdb_tag,
    input  logic [CDB_W-1:0][XLEN-1:0]              cdb_value,
    input  logic [ROB_IDX_W:0]                      rob_free,
    input  logic [DISP_W-1:0][ROB_IDX_W-1:0]        rob_alloc_idx,
    output logic [DISP_W-1:0]                       rob_alloc_en,
    output logic [DISP_W-1:0]                       rs_alloc_en,
    output logic [DISP_W-1:0]                       lsu_alloc_en,
    output dispatch_uop_t [DISP_W-1:0]              disp_uop,
    output logic [DISP_W-1:0][ROB_IDX_W-1:0]        disp_rob_idx,
    output logic [DISP_W-1:0][XLEN-1:0]             disp_src1_val,
    output logic [DISP_W-1:0][XLEN-1:0]             disp_src2_val,
    output logic [DISP_W-1:0]                       disp_src1_ready,
    output logic [DISP_W-1:0]                       disp_src2_ready,
    input  logic [$clog2(RS_CREDITS+1)-1:0]         rs_release,
    input  logic [$clog2(LSU_CREDITS+1)-1:0]        lsu_release
);

    localparam int unsigned PTR_W  = $clog2(DQ_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RS_CW  = $clog2(RS_CREDITS + 1);
    localparam int unsigned LSU_CW = $clog2(LSU_CREDITS + 1);

    dispatch_uop_t           mem_q [DQ_DEPTH];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [RS_CW-1:0]        rs_cnt_q, rs_cnt_d;
    logic [LSU_CW-1:0]       lsu_cnt_q, lsu_cnt_d;

    dispatch_uop_t           head_uop [DISP_W];
    logic [DISP_W-1:0]       lane_valid, lane_mem;
    logic [CNT_W-1:0]        enq_cnt, disp_cnt;
    logic                    enq_fire;
    logic [RS_CW-1:0]        rs_used;
    logic [LSU_CW-1:0]       lsu_used;
    int unsigned             mem_used;
    logic                    scan_ok;
    logic [RS_CW:0]          rs_sum;
    logic [LSU_CW:0]         lsu_sum;
    logic [2*DISP_W-1:0]     sb_ready;
    logic [DISP_W-1:0]       sb_clr_en;
    logic [DISP_W-1:0][PHYS_W-1:0] sb_clr_tag;

    // ---------------- enqueue ----------------
    // Ready uses the current count only; same-cycle dispatch frees nothing here.
    assign ren_ready = !flush_pipeline &&
                       ((CNT_W'(DQ_DEPTH) - count_q) >= CNT_W'(FETCH_W));
    assign enq_fire  = ren_ready && (|ren_valid);

    always_comb begin
        enq_cnt = '0;
        if (enq_fire) begin
            for (int i = 0; i < FETCH_W; i++) enq_cnt = enq_cnt + CNT_W'(ren_valid[i]);
        end
    end

    // ---------------- head lanes ----------------
    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            head_uop[k]   = mem_q[head_q + PTR_W'(k)];
            lane_valid[k] = CNT_W'(k) < count_q;
            lane_mem[k]   = is_mem_class(head_uop[k].uclass);
        end
    end

    // ---------------- in-order dispatch scan ----------------
    always_comb begin
        rob_alloc_en = '0;
        rs_alloc_en  = '0;
        lsu_alloc_en = '0;
        rs_used      = '0;
        lsu_used     = '0;
        mem_used     = 0;
        disp_cnt     = '0;
        scan_ok      = !flush_pipeline;
        for (int k = 0; k < DISP_W; k++) begin
            if (scan_ok && lane_valid[k] && (rob_free > (ROB_IDX_W+1)'(k))) begin
                if (lane_mem[k]) begin
                    if ((lsu_cnt_q > lsu_used) && (mem_used < MEM_PER_CYCLE)) begin
                        rob_alloc_en[k] = 1'b1;
                        lsu_alloc_en[k] = 1'b1;
                        lsu_used        = lsu_used + LSU_CW'(1);
                        mem_used        = mem_used + 1;
                        disp_cnt        = disp_cnt + CNT_W'(1);
                    end else begin
                        scan_ok = 1'b0;
                    end
                end else if (rs_cnt_q > rs_used) begin
                    rob_alloc_en[k] = 1'b1;
                    rs_alloc_en[k]  = 1'b1;
                    rs_used         = rs_used + RS_CW'(1);
                    disp_cnt        = disp_cnt + CNT_W'(1);
                end else begin
                    scan_ok = 1'b0;
                end
            end else begin
                scan_ok = 1'b0;
            end
        end
    end

    // ---------------- payload and operands ----------------
    always_comb begin
        logic              src_v;
        logic [PHYS_W-1:0] tag;
        logic              rdy;
        logic [XLEN-1:0]   val;
        disp_uop        = '0;
        disp_rob_idx    = '0;
        disp_src1_val   = '0;
        disp_src2_val   = '0;
        disp_src1_ready = '0;
        disp_src2_ready = '0;
        prf_rtag        = '0;
        for (int k = 0; k < DISP_W; k++) begin
            if (lane_valid[k]) begin
                disp_uop[k]       = head_uop[k];
                disp_rob_idx[k]   = rob_alloc_idx[k];
                prf_rtag[2*k]     = head_uop[k].prs1;
                prf_rtag[2*k + 1] = head_uop[k].prs2;
            end
            for (int s = 0; s < 2; s++) begin
                src_v = (s == 0) ? head_uop[k].rs1_valid : head_uop[k].rs2_valid;
                tag   = (s == 0) ? head_uop[k].prs1 : head_uop[k].prs2;
                rdy   = 1'b1;
                val   = '0;
                if (!src_v) begin
                    val = (s == 0) ? '0 : head_uop[k].imm;
                end else if (tag != '0) begin
                    rdy = sb_ready[2*k + s];
                    val = prf_rdata[2*k + s];
                    // Ascending scan: the highest matching CDB port wins.
                    for (int c = 0; c < CDB_W; c++) begin
                        if (cdb_valid[c] && (cdb_tag[c] == tag)) begin
                            rdy = 1'b1;
                            val = cdb_value[c];
                        end
                    end
                    // Producer in an older lane of this group: not ready yet.
                    for (int j = 0; j < DISP_W; j++) begin
                        if ((j < k) && rob_alloc_en[j] && head_uop[j].rd_valid &&
                            (head_uop[j].prd == tag)) begin
                            rdy = 1'b0;
                        end
                    end
                end
                if (!lane_valid[k]) begin
                    rdy = 1'b0;
                    val = '0;
                end
                if (s == 0) begin
                    disp_src1_ready[k] = rdy;
                    disp_src1_val[k]   = val;
                end else begin
                    disp_src2_ready[k] = rdy;
                    disp_src2_val[k]   = val;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            sb_clr_en[k]  = rob_alloc_en[k] && head_uop[k].rd_valid && (head_uop[k].prd != '0);
            sb_clr_tag[k] = head_uop[k].prd;
        end
    end

    dispatch_scoreboard #(
        .PHYS_W (PHYS_W),
        .DISP_W (DISP_W),
        .CDB_W  (CDB_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush_pipeline),
        .clr_en   (sb_clr_en),
        .clr_tag  (sb_clr_tag),
        .set_en   (cdb_valid),
        .set_tag  (cdb_tag),
        .rd_tag   (prf_rtag),
        .rd_ready (sb_ready)
    );

    // ---------------- next state ----------------
    always_comb begin
        rs_sum  = (RS_CW+1)'(rs_cnt_q) - (RS_CW+1)'(rs_used) + (RS_CW+1)'(rs_release);
        lsu_sum = (LSU_CW+1)'(lsu_cnt_q) - (LSU_CW+1)'(lsu_used) + (LSU_CW+1)'(lsu_release);
        rs_cnt_d  = (rs_sum > (RS_CW+1)'(RS_CREDITS)) ? RS_CW'(RS_CREDITS) : rs_sum[RS_CW-1:0];
        lsu_cnt_d = (lsu_sum > (LSU_CW+1)'(LSU_CREDITS)) ? LSU_CW'(LSU_CREDITS)
                                                        : lsu_sum[LSU_CW-1:0];
        head_d  = head_q + PTR_W'(disp_cnt);
        tail_d  = tail_q + PTR_W'(enq_cnt);
        count_d = count_q - disp_cnt + enq_cnt;
        if (flush_pipeline) begin
            rs_cnt_d  = RS_CW'(RS_CREDITS);
            lsu_cnt_d = LSU_CW'(LSU_CREDITS);
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DQ_DEPTH; i++) mem_q[i] <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rs_cnt_q  <= RS_CW'(RS_CREDITS);
            lsu_cnt_q <= LSU_CW'(LSU_CREDITS);
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rs_cnt_q  <= rs_cnt_d;
            lsu_cnt_q <= lsu_cnt_d;
            for (int i = 0; i < FETCH_W; i++) begin
                if (enq_fire && ren_valid[i]) mem_q[tail_q + PTR_W'(i)] <= ren_uop[i];
            end
        end
    end

    // Credit return beyond capacity means the consumer double-released.
    always_ff @(posedge clk) begin
        if (reset_n && !flush_pipeline) begin
            assert (rs_sum <= (RS_CW+1)'(RS_CREDITS));
            assert (lsu_sum <= (LSU_CW+1)'(LSU_CREDITS));
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
    import core_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                flush_pipeline = 1'b0;
    logic [1:0]          ren_valid = '0;
    dispatch_uop_t [1:0] ren_uop = '0;
    logic                ren_ready;
    logic [3:0][5:0]     prf_rtag;
    logic [3:0][31:0]    prf_rdata;
    logic [1:0]          cdb_valid = '0;
    logic [1:0][5:0]     cdb_tag = '0;
    logic [1:0][31:0]    cdb_value = '0;
    logic [5:0]          rob_free = 6'd8;
    logic [1:0][4:0]     rob_alloc_idx = {5'd4, 5'd3};
    logic [1:0]          rob_alloc_en, rs_alloc_en, lsu_alloc_en;
    dispatch_uop_t [1:0] disp_uop;
    logic [1:0][4:0]     disp_rob_idx;
    logic [1:0][31:0]    disp_src1_val, disp_src2_val;
    logic [1:0]          disp_src1_ready, disp_src2_ready;
    logic [4:0]          rs_release = '0;
    logic [3:0]          lsu_release = '0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // PRF model: value is a recognisable function of the tag.
    always_comb begin
        for (int i = 0; i < 4; i++) prf_rdata[i] = 32'h1000 + 32'(prf_rtag[i]);
    end

    dispatch_queue dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush_pipeline  (flush_pipeline),
        .ren_valid       (ren_valid),
        .ren_uop         (ren_uop),
        .ren_ready       (ren_ready),
        .prf_rtag        (prf_rtag),
        .prf_rdata       (prf_rdata),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .rob_free        (rob_free),
        .rob_alloc_idx   (rob_alloc_idx),
        .rob_alloc_en    (rob_alloc_en),
        .rs_alloc_en     (rs_alloc_en),
        .lsu_alloc_en    (lsu_alloc_en),
        .disp_uop        (disp_uop),
        .disp_rob_idx    (disp_rob_idx),
        .disp_src1_val   (disp_src1_val),
        .disp_src2_val   (disp_src2_val),
        .disp_src1_ready (disp_src1_ready),
        .disp_src2_ready (disp_src2_ready),
        .rs_release      (rs_release),
        .lsu_release     (lsu_release)
    );

    function automatic dispatch_uop_t mk(input uop_class_e c, input logic r1v,
                                         input logic [5:0] p1, input logic r2v,
                                         input logic [5:0] p2, input logic rdv,
                                         input logic [5:0] pd, input logic [31:0] imm);
        dispatch_uop_t u;
        u = '0;
        u.uclass = c;
        u.rs1_valid = r1v;
        u.prs1 = p1;
        u.rs2_valid = r2v;
        u.prs2 = p2;
        u.rd_valid = rdv;
        u.prd = pd;
        u.imm = imm;
        return u;
    endfunction

    dispatch_uop_t alu_nop;
    initial alu_nop = mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0);

    // Present a rename group for one edge; returns just after the next negedge.
    task automatic push(input logic [1:0] v, input dispatch_uop_t u0, input dispatch_uop_t u1);
        ren_valid  = v;
        ren_uop[0] = u0;
        ren_uop[1] = u1;
        @(posedge clk);
        @(negedge clk);
        ren_valid = '0;
        ren_uop   = '0;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_flush;
        flush_pipeline = 1'b1;
        tick();
        flush_pipeline = 1'b0;
        #1;
    endtask

    task automatic run_alu(input int pairs, input bit single);
        for (int i = 0; i < pairs; i++) begin
            push(2'b11, alu_nop, alu_nop);
            tick();
        end
        if (single) begin
            push(2'b01, alu_nop, alu_nop);
            tick();
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (ren_ready !== 1'b1) $display("FAIL reset_ren_ready got %b want 1", ren_ready); else passed++;
        total++; if ({rob_alloc_en, rs_alloc_en, lsu_alloc_en} !== 6'b0)
            $display("FAIL reset_alloc got %b want 000000", {rob_alloc_en, rs_alloc_en, lsu_alloc_en}); else passed++;
        total++; if (disp_uop !== '0) $display("FAIL reset_disp_uop got %h want 0", disp_uop); else passed++;
        total++; if ({disp_src1_val, disp_src2_val} !== '0)
            $display("FAIL reset_src_val got %h want 0", {disp_src1_val, disp_src2_val}); else passed++;
    endtask

    task automatic test_alu_pair;
        push(2'b11, mk(UC_ALU, 1'b1, 6'd1, 1'b0, 6'd0, 1'b1, 6'd5, 32'h0),
                    mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd6, 32'h55));
        total++; if (rob_alloc_en !== 2'b11) $display("FAIL alu_rob_alloc got %b want 11", rob_alloc_en); else passed++;
        total++; if (rs_alloc_en !== 2'b11) $display("FAIL alu_rs_alloc got %b want 11", rs_alloc_en); else passed++;
        total++; if (lsu_alloc_en !== 2'b00) $display("FAIL alu_lsu_alloc got %b want 00", lsu_alloc_en); else passed++;
        total++; if (disp_src1_val[0] !== 32'h1001 || disp_src1_ready[0] !== 1'b1)
            $display("FAIL alu_src1_l0 got %h/%b want 00001001/1", disp_src1_val[0], disp_src1_ready[0]); else passed++;
        total++; if (disp_src2_val[1] !== 32'h55 || disp_src2_ready[1] !== 1'b1)
            $display("FAIL alu_imm_l1 got %h/%b want 00000055/1", disp_src2_val[1], disp_src2_ready[1]); else passed++;
        total++; if (disp_rob_idx[1] !== 5'd4) $display("FAIL alu_rob_idx got %0d want 4", disp_rob_idx[1]); else passed++;
        tick();
    endtask

    task automatic test_scoreboard_cdb;
        push(2'b01, mk(UC_ALU, 1'b1, 6'd5, 1'b1, 6'd6, 1'b0, 6'd0, 32'h0), alu_nop);
        total++; if ({disp_src1_ready[0], disp_src2_ready[0]} !== 2'b00)
            $display("FAIL sb_cleared got %b want 00", {disp_src1_ready[0], disp_src2_ready[0]}); else passed++;
        total++; if (disp_src1_val[0] !== 32'h1005) $display("FAIL sb_prf_val got %h want 00001005", disp_src1_val[0]); else passed++;
        cdb_valid = 2'b01; cdb_tag[0] = 6'd5; cdb_value[0] = 32'hAAAA;
        #1;
        total++; if (disp_src1_ready[0] !== 1'b1 || disp_src1_val[0] !== 32'hAAAA)
            $display("FAIL cdb_bypass got %b/%h want 1/0000aaaa", disp_src1_ready[0], disp_src1_val[0]); else passed++;
        cdb_valid = 2'b11; cdb_tag[1] = 6'd5; cdb_value[1] = 32'hBBBB;
        #1;
        total++; if (disp_src1_val[0] !== 32'hBBBB) $display("FAIL cdb_high_port got %h want 0000bbbb", disp_src1_val[0]); else passed++;
        total++; if (disp_src2_ready[0] !== 1'b0) $display("FAIL cdb_other_src got %b want 0", disp_src2_ready[0]); else passed++;
        tick();
        cdb_valid = '0;
        push(2'b11, mk(UC_ALU, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0),
                    mk(UC_ALU, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 32'h77));
        total++; if (disp_src1_ready[0] !== 1'b1) $display("FAIL sb_set_by_cdb got %b want 1", disp_src1_ready[0]); else passed++;
        total++; if (disp_src2_ready[1] !== 1'b1 || disp_src2_val[1] !== 32'h0)
            $display("FAIL p0_src got %b/%h want 1/00000000", disp_src2_ready[1], disp_src2_val[1]); else passed++;
        tick();
    endtask

    task automatic test_intra_group;
        push(2'b11, mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd7, 32'h0),
                    mk(UC_ALU, 1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0));
        cdb_valid = 2'b01; cdb_tag[0] = 6'd7; cdb_value[0] = 32'h1234;
        #1;
        total++; if (disp_src1_ready[1] !== 1'b0) $display("FAIL intra_dep got %b want 0", disp_src1_ready[1]); else passed++;
        total++; if (rob_alloc_en !== 2'b11) $display("FAIL intra_alloc got %b want 11", rob_alloc_en); else passed++;
        tick();
        cdb_valid = '0;
        push(2'b01, mk(UC_ALU, 1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0), alu_nop);
        total++; if (disp_src1_ready[0] !== 1'b0) $display("FAIL clear_wins got %b want 0", disp_src1_ready[0]); else passed++;
        tick();
    endtask

    task automatic test_loads;
        dispatch_uop_t ld;
        ld = mk(UC_LOAD, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        push(2'b11, ld, ld);
        total++; if (lsu_alloc_en !== 2'b01) $display("FAIL load1_lsu got %b want 01", lsu_alloc_en); else passed++;
        total++; if ({rob_alloc_en, rs_alloc_en} !== 4'b0100)
            $display("FAIL load1_rob_rs got %b want 0100", {rob_alloc_en, rs_alloc_en}); else passed++;
        tick();
        total++; if (lsu_alloc_en !== 2'b01) $display("FAIL load2_lsu got %b want 01", lsu_alloc_en); else passed++;
        tick();
        total++; if (rob_alloc_en !== 2'b00) $display("FAIL load_drained got %b want 00", rob_alloc_en); else passed++;
    endtask

    task automatic test_flush;
        do_flush();
        run_alu(6, 1'b0);
        push(2'b01, mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9, 32'h0), alu_nop);
        tick();
        // 13 RS credits used: 3 remain. Hold 5 entries with no ROB space.
        rob_free = 6'd0;
        push(2'b11, mk(UC_ALU, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0), alu_nop);
        push(2'b11, alu_nop, alu_nop);
        push(2'b01, alu_nop, alu_nop);
        total++; if (rob_alloc_en !== 2'b00) $display("FAIL rob_full_block got %b want 00", rob_alloc_en); else passed++;
        total++; if (disp_src1_ready[0] !== 1'b0) $display("FAIL pre_flush_sb got %b want 0", disp_src1_ready[0]); else passed++;
        total++; if (ren_ready !== 1'b1) $display("FAIL count5_ready got %b want 1", ren_ready); else passed++;
        rob_free = 6'd8;
        flush_pipeline = 1'b1;
        rs_release = 5'd2;
        #1;
        total++; if ({rob_alloc_en, rs_alloc_en, lsu_alloc_en} !== 6'b0)
            $display("FAIL flush_alloc got %b want 000000", {rob_alloc_en, rs_alloc_en, lsu_alloc_en}); else passed++;
        total++; if (ren_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", ren_ready); else passed++;
        tick();
        flush_pipeline = 1'b0;
        rs_release = '0;
        #1;
        total++; if (rob_alloc_en !== 2'b00) $display("FAIL post_flush_empty got %b want 00", rob_alloc_en); else passed++;
        total++; if (ren_ready !== 1'b1) $display("FAIL post_flush_ready got %b want 1", ren_ready); else passed++;
        push(2'b11, alu_nop, alu_nop);
        total++; if (rs_alloc_en !== 2'b11) $display("FAIL post_flush_rs_a got %b want 11", rs_alloc_en); else passed++;
        push(2'b11, alu_nop, alu_nop);
        total++; if (rs_alloc_en !== 2'b11) $display("FAIL post_flush_rs_b got %b want 11", rs_alloc_en); else passed++;
        tick();
        push(2'b01, mk(UC_ALU, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0), alu_nop);
        total++; if (disp_src1_ready[0] !== 1'b1) $display("FAIL post_flush_sb got %b want 1", disp_src1_ready[0]); else passed++;
        tick();
    endtask

    task automatic test_rs_credits;
        do_flush();
        run_alu(7, 1'b1);
        push(2'b11, alu_nop, alu_nop);
        total++; if (rs_alloc_en !== 2'b01) $display("FAIL rs_one_credit got %b want 01", rs_alloc_en); else passed++;
        total++; if (rob_alloc_en !== 2'b01) $display("FAIL rs_one_rob got %b want 01", rob_alloc_en); else passed++;
        tick();
        rs_release = 5'd1;
        #1;
        total++; if (rs_alloc_en !== 2'b00) $display("FAIL rs_zero_credit got %b want 00", rs_alloc_en); else passed++;
        tick();
        rs_release = '0;
        #1;
        total++; if (rs_alloc_en !== 2'b01) $display("FAIL rs_released got %b want 01", rs_alloc_en); else passed++;
        tick();
        rs_release = 5'd16;
        tick();
        rs_release = '0;
        #1;
    endtask

    task automatic test_fill_wrap;
        run_alu(2, 1'b0);
        rob_free = 6'd0;
        for (int i = 0; i < 3; i++) begin
            push(2'b11, mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'(2*i)),
                        mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'(2*i+1)));
        end
        total++; if (ren_ready !== 1'b1) $display("FAIL count6_ready got %b want 1", ren_ready); else passed++;
        push(2'b01, mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd6), alu_nop);
        total++; if (ren_ready !== 1'b0) $display("FAIL count7_ready got %b want 0", ren_ready); else passed++;
        push(2'b11, mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd8),
                    mk(UC_ALU, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd9));
        total++; if (ren_ready !== 1'b0) $display("FAIL full_reject got %b want 0", ren_ready); else passed++;
        rob_free = 6'd8;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++; if (rob_alloc_en !== 2'b11) $display("FAIL drain%0d_alloc got %b want 11", d, rob_alloc_en); else passed++;
            total++; if (disp_uop[0].imm !== 32'(2*d) || disp_uop[1].imm !== 32'(2*d+1))
                $display("FAIL drain%0d_order got %0d,%0d want %0d,%0d", d, disp_uop[0].imm, disp_uop[1].imm, 2*d, 2*d+1);
            else passed++;
            total++; if (ren_ready !== (d != 0)) $display("FAIL drain%0d_ready got %b want %b", d, ren_ready, (d != 0)); else passed++;
            tick();
        end
        total++; if (rob_alloc_en !== 2'b01 || disp_uop[0].imm !== 32'd6)
            $display("FAIL drain_last got %b/%0d want 01/6", rob_alloc_en, disp_uop[0].imm); else passed++;
        tick();
        total++; if (rob_alloc_en !== 2'b00) $display("FAIL drain_empty got %b want 00", rob_alloc_en); else passed++;
    endtask

    task automatic test_reset_mid;
        rob_free = 6'd0;
        push(2'b11, alu_nop, alu_nop);
        rob_free = 6'd8;
        #1;
        total++; if (rob_alloc_en !== 2'b11) $display("FAIL mid_pre got %b want 11", rob_alloc_en); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (rob_alloc_en !== 2'b00 || ren_ready !== 1'b1)
            $display("FAIL mid_async got %b/%b want 00/1", rob_alloc_en, ren_ready); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (rob_alloc_en !== 2'b00) $display("FAIL mid_discard got %b want 00", rob_alloc_en); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu_pair();
        test_scoreboard_cdb();
        test_intra_group();
        test_loads();
        test_flush();
        test_rs_credits();
        test_fill_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
